// File: rtl/umi_packet_merge.sv
// umi_packet_merge
// Merges consecutive, contiguous UMI posted writes of width IDW into wider
// ODW packets. Anything that cannot merge leaves with its width converted and
// otherwise untouched. One packet is held at a time; strict in-order.
// Optional build macro UMI_MERGE_TIMEOUT_EN: a held packet left idle in ACCUM
// for TIMEOUT cycles is flushed automatically.
//
// state | meaning
// IDLE  | nothing held; next accepted input is loaded
// ACCUM | posted write held; contiguous posted writes are merged into it
// FLUSH | held packet presented on the output until accepted
module umi_packet_merge #(
  parameter int CW      = 32,
  parameter int AW      = 64,
  parameter int IDW     = 64,
  parameter int ODW     = 256,
  parameter int ALIGN   = 1,
  parameter int TIMEOUT = 16
) (
  input  logic           umi_in_clk,
  input  logic           umi_in_nreset,
  input  logic           flush,
  input  logic           umi_in_valid,
  input  logic [CW-1:0]  umi_in_cmd,
  input  logic [AW-1:0]  umi_in_dstaddr,
  input  logic [AW-1:0]  umi_in_srcaddr,
  input  logic [IDW-1:0] umi_in_data,
  output logic           umi_in_ready,
  output logic           umi_out_valid,
  output logic [CW-1:0]  umi_out_cmd,
  output logic [AW-1:0]  umi_out_dstaddr,
  output logic [AW-1:0]  umi_out_srcaddr,
  output logic [ODW-1:0] umi_out_data,
  input  logic           umi_out_ready,
  output logic           merge_active
);

  localparam int OB = ODW / 8;
  localparam int LB = $clog2(OB);
  localparam int BW = LB + 1;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  // len and eom are the only command fields allowed to differ when merging
  localparam logic [CW-1:0] NOMERGE_MASK = CW'(32'h0040_FF00);

  if (IDW > ODW) begin : g_bad_width
    $fatal(1, "umi_packet_merge: IDW must not exceed ODW");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $fatal(1, "umi_packet_merge: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ready_en;
  logic [CW-1:0]    r_acc_cmd;
  logic [AW-1:0]    r_acc_dst;
  logic [AW-1:0]    r_acc_src;
  logic [ODW-1:0]   r_acc_data;
  logic [BW-1:0]    r_acc_bytes;

  // umi_unpack equivalent: command field decode
  logic [4:0]       w_in_op;
  logic [2:0]       w_in_size;
  logic [7:0]       w_in_len;
  logic             w_in_eom;
  logic [16:0]      w_in_bytes;
  logic [16:0]      w_sum;
  logic [AW-1:0]    w_exp_dst;
  logic [LB-1:0]    w_end_low;
  logic             w_align_ok;
  logic             w_cmd_match;
  logic             w_mergeable;
  logic             w_merge_done;
  logic             w_load_accum;
  logic             w_accept;
  logic             w_timeout;
  logic [7:0]       w_merge_len;
  logic [CW-1:0]    w_merge_cmd;
  logic [ODW-1:0]   w_merge_data;

  assign w_in_op    = umi_in_cmd[4:0];
  assign w_in_size  = umi_in_cmd[7:5];
  assign w_in_len   = umi_in_cmd[15:8];
  assign w_in_eom   = umi_in_cmd[22];
  assign w_in_bytes = 17'({1'b0, w_in_len} + 9'd1) << w_in_size;

  assign w_sum      = 17'(r_acc_bytes) + w_in_bytes;
  assign w_exp_dst  = r_acc_dst + AW'(r_acc_bytes);
  assign w_end_low  = r_acc_dst[LB-1:0] + w_sum[LB-1:0];
  assign w_align_ok = (ALIGN == 0) ||
                      (r_acc_dst[AW-1:LB] == umi_in_dstaddr[AW-1:LB]);
  assign w_cmd_match = ((umi_in_cmd ^ r_acc_cmd) & ~NOMERGE_MASK) == '0;

  assign w_mergeable = (r_state == S_ACCUM) &&
                       (w_in_op == REQ_POSTED) &&
                       w_cmd_match &&
                       (umi_in_srcaddr == r_acc_src) &&
                       (umi_in_dstaddr == w_exp_dst) &&
                       (w_sum <= 17'(OB)) &&
                       w_align_ok;

  // after a merge: stop on eom, on a full packet, or when the next byte
  // would start a new ODW-aligned line
  assign w_merge_done = w_in_eom || (w_sum == 17'(OB)) ||
                        ((ALIGN != 0) && (w_end_low == '0));

  assign w_load_accum = (w_in_op == REQ_POSTED) && !w_in_eom &&
                        (w_in_bytes < 17'(OB));

  assign w_accept = umi_in_valid & umi_in_ready;

  // umi_pack equivalent: merged length rescaled to the held packet's size
  assign w_merge_len  = 8'((w_sum >> r_acc_cmd[7:5]) - 17'd1);
  assign w_merge_data = r_acc_data | (ODW'(umi_in_data) << {r_acc_bytes, 3'b000});

  // merged command keeps every field of the held packet except len and eom
  always_comb begin
    w_merge_cmd       = r_acc_cmd;
    w_merge_cmd[15:8] = w_merge_len;
    w_merge_cmd[22]   = w_in_eom;
  end

`ifdef UMI_MERGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] r_idle_cnt;

  // idle counter: runs only while holding in ACCUM with no accepted input
  always_ff @(posedge umi_in_clk or negedge umi_in_nreset) begin
    if (!umi_in_nreset)
      r_idle_cnt <= '0;
    else if (w_accept || (r_state != S_ACCUM))
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= r_idle_cnt + TW'(1);
  end

  assign w_timeout = (r_state == S_ACCUM) && !w_accept &&
                     (r_idle_cnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // state register; ready enable holds off the input for one cycle after reset
  always_ff @(posedge umi_in_clk or negedge umi_in_nreset) begin
    if (!umi_in_nreset) begin
      r_state    <= S_IDLE;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ready_en <= 1'b1;
    end
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = w_load_accum ? S_ACCUM : S_FLUSH;
      end
      S_ACCUM: begin
        if (w_accept)
          w_state_nxt = (w_merge_done || flush) ? S_FLUSH : S_ACCUM;
        else if (umi_in_valid || flush || w_timeout)
          w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (umi_out_ready) begin
          if (w_accept)
            w_state_nxt = w_load_accum ? S_ACCUM : S_FLUSH;
          else
            w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // handshake and status outputs per state
  always_comb begin
    umi_in_ready  = 1'b0;
    umi_out_valid = 1'b0;
    merge_active  = 1'b0;
    case (r_state)
      S_IDLE:  umi_in_ready = r_ready_en;
      S_ACCUM: begin
        umi_in_ready = w_mergeable;
        merge_active = 1'b1;
      end
      S_FLUSH: begin
        umi_in_ready  = umi_out_ready;
        umi_out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // held packet: merge in ACCUM, otherwise load (empty or replaced on send)
  always_ff @(posedge umi_in_clk or negedge umi_in_nreset) begin
    if (!umi_in_nreset) begin
      r_acc_cmd   <= '0;
      r_acc_dst   <= '0;
      r_acc_src   <= '0;
      r_acc_data  <= '0;
      r_acc_bytes <= '0;
    end else if (w_accept) begin
      if (r_state == S_ACCUM) begin
        r_acc_cmd   <= w_merge_cmd;
        r_acc_data  <= w_merge_data;
        r_acc_bytes <= BW'(w_sum);
      end else begin
        r_acc_cmd   <= umi_in_cmd;
        r_acc_dst   <= umi_in_dstaddr;
        r_acc_src   <= umi_in_srcaddr;
        r_acc_data  <= ODW'(umi_in_data);
        r_acc_bytes <= BW'(w_in_bytes);
      end
    end
  end

  assign umi_out_cmd     = r_acc_cmd;
  assign umi_out_dstaddr = r_acc_dst;
  assign umi_out_srcaddr = r_acc_src;
  assign umi_out_data    = r_acc_data;

endmodule

// File: tb/tb_umi_packet_merge.sv
// Directed bench for umi_packet_merge (CW=32, AW=64, IDW=64, ODW=256, ALIGN=1).
// A packet-level model predicts the output packet sequence; one process
// checks every output transfer and hold-stability against it.
module tb_umi_packet_merge;

  localparam logic [63:0] SRC = 64'h0000_0000_ABCD_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_cmd = '0;
  logic [63:0]  in_dst = '0;
  logic [63:0]  in_src = '0;
  logic [63:0]  in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [31:0]  out_cmd;
  logic [63:0]  out_dst;
  logic [63:0]  out_src;
  logic [255:0] out_data;
  logic         out_ready = 1'b1;
  logic         merge_active;

  umi_packet_merge #(.CW(32), .AW(64), .IDW(64), .ODW(256), .ALIGN(1), .TIMEOUT(16)) dut (
    .umi_in_clk(clk), .umi_in_nreset(rst_n), .flush(flush),
    .umi_in_valid(in_valid), .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst),
    .umi_in_srcaddr(in_src), .umi_in_data(in_data), .umi_in_ready(in_ready),
    .umi_out_valid(out_valid), .umi_out_cmd(out_cmd), .umi_out_dstaddr(out_dst),
    .umi_out_srcaddr(out_src), .umi_out_data(out_data), .umi_out_ready(out_ready),
    .merge_active(merge_active)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]  cmd;
    logic [63:0]  dst;
    logic [63:0]  src;
    logic [255:0] data;
    int           bytes;
  } pkt_t;

  pkt_t exp_q[$];
  pkt_t m_held;
  bit   m_valid = 0;
  pkt_t last_out;
  int   n_out = 0;
  int   last_wait = 0;

  function automatic logic [31:0] mkcmd(logic [4:0] op, logic [2:0] sz, logic [7:0] ln, logic eom);
    return {5'h03, 2'b00, 1'b0, 1'b0, eom, 2'b00, 4'h0, ln, sz, op};
  endfunction

  function automatic int nbytes(logic [31:0] c);
    return (int'(c[15:8]) + 1) << c[7:5];
  endfunction

  function automatic bit can_merge(pkt_t h, pkt_t p);
    logic [31:0] a, b;
    a = h.cmd; b = p.cmd;
    a[15:8] = '0; a[22] = 1'b0;
    b[15:8] = '0; b[22] = 1'b0;
    return (p.cmd[4:0] == 5'h05) && (a == b) && (h.src == p.src) &&
           (p.dst == h.dst + 64'(h.bytes)) && (h.bytes + p.bytes <= 32) &&
           ((h.dst / 64'd32) == (p.dst / 64'd32));
  endfunction

  // a presented input that cannot join the held packet forces it out first
  task automatic model_pre(input pkt_t p);
    if (m_valid && !can_merge(m_held, p)) begin
      exp_q.push_back(m_held);
      m_valid = 0;
    end
  endtask

  task automatic model_accept(input pkt_t p);
    if (m_valid) begin
      m_held.data  = m_held.data | (p.data << (m_held.bytes * 8));
      m_held.bytes = m_held.bytes + p.bytes;
      m_held.cmd[15:8] = 8'((m_held.bytes >> m_held.cmd[7:5]) - 1);
      m_held.cmd[22]   = p.cmd[22];
      if (p.cmd[22] || m_held.bytes == 32 || ((m_held.dst + 64'(m_held.bytes)) % 64'd32) == 0) begin
        exp_q.push_back(m_held);
        m_valid = 0;
      end
    end else if (p.cmd[4:0] == 5'h05 && !p.cmd[22] && p.bytes < 32) begin
      m_held  = p;
      m_valid = 1;
    end else begin
      exp_q.push_back(p);
    end
  endtask

  task automatic model_flush();
    if (m_valid) begin
      exp_q.push_back(m_held);
      m_valid = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] c, input logic [63:0] d, input logic [63:0] dat);
    pkt_t p;
    int n;
    p.cmd = c; p.dst = d; p.src = SRC; p.data = 256'(dat); p.bytes = nbytes(c);
    model_pre(p);
    in_valid = 1'b1; in_cmd = c; in_dst = d; in_src = SRC; in_data = dat;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    last_wait = n;
    chk("send_accept", 256'(in_ready), 256'(1'b1));
    if (in_ready) begin
      @(posedge clk); #1;
      model_accept(p);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
  endtask

  // output checker: every transfer against the model, holds must be stable
  pkt_t prev;
  bit   stall = 0;
  always @(negedge clk) begin
    pkt_t e;
    if (!rst_n) begin
      stall = 0;
    end else begin
      if (stall) begin
        chk("hold_valid", 256'(out_valid), 256'(1'b1));
        chk("hold_cmd", 256'(out_cmd), 256'(prev.cmd));
        chk("hold_dst", 256'(out_dst), 256'(prev.dst));
        chk("hold_data", out_data, prev.data);
      end
      stall = out_valid && !out_ready;
      prev.cmd = out_cmd; prev.dst = out_dst; prev.data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 256'(out_dst), 256'(64'hFFFF_FFFF_FFFF_FFFF));
        end else begin
          e = exp_q.pop_front();
          chk("out_cmd", 256'(out_cmd), 256'(e.cmd));
          chk("out_dst", 256'(out_dst), 256'(e.dst));
          chk("out_src", 256'(out_src), 256'(e.src));
          chk("out_data", out_data, e.data);
        end
        last_out.cmd = out_cmd; last_out.dst = out_dst;
        last_out.src = out_src; last_out.data = out_data;
        n_out++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pw, rd, wr;
    logic [63:0] d [4];
    int first, n0;

    // reset values
    #12;
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_in_ready", 256'(in_ready), 256'(1'b0));
    chk("rst_merge_active", 256'(merge_active), 256'(1'b0));
    chk("rst_out_cmd", 256'(out_cmd), 256'(0));
    chk("rst_out_data", out_data, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 256'(in_ready), 256'(1'b0));
    @(posedge clk); #1;
    chk("ready_one_cycle_later", 256'(in_ready), 256'(1'b1));
    idle(1);

    // contiguous merge of four 8-byte posted writes
    d[0] = 64'h1111_0000_0000_0000; d[1] = 64'h2222_0000_0000_0001;
    d[2] = 64'h3333_0000_0000_0002; d[3] = 64'h4444_0000_0000_0003;
    for (int i = 0; i < 4; i++) begin
      send(mkcmd(5'h05, 3'd3, 8'd0, (i == 3)), 64'h1000 + 64'(i * 8), d[i]);
      chk("contig_no_wait", 256'(last_wait), 256'(0));
      if (i < 3) chk("contig_active", 256'(merge_active), 256'(1'b1));
    end
    chk("contig_valid_next", 256'(out_valid), 256'(1'b1));
    chk("contig_dst", 256'(out_dst), 256'(64'h1000));
    chk("contig_len", 256'(out_cmd[15:8]), 256'(3));
    chk("contig_eom", 256'(out_cmd[22]), 256'(1'b1));
    chk("contig_data", out_data, {64'h4444_0000_0000_0003, 64'h3333_0000_0000_0002,
                                  64'h2222_0000_0000_0001, 64'h1111_0000_0000_0000});
    idle(3);

    // address gap
    pw = mkcmd(5'h05, 3'd3, 8'd0, 1'b0);
    send(pw, 64'h1000, 64'hA0);
    send(pw, 64'h2000, 64'hA1);
    chk("gap_wait", 256'(last_wait), 256'(1));
    chk("gap_first_dst", 256'(last_out.dst), 256'(64'h1000));
    chk("gap_first_len", 256'(last_out.cmd[15:8]), 256'(0));
    chk("gap_second_held", 256'(merge_active), 256'(1'b1));
    do_flush();
    idle(3);
    chk("gap_second_dst", 256'(last_out.dst), 256'(64'h2000));
    chk("gap_second_len", 256'(last_out.cmd[15:8]), 256'(0));

    // ALIGN boundary
    send(pw, 64'h10F8, 64'hB0);
    send(pw, 64'h1100, 64'hB1);
    chk("align_wait", 256'(last_wait), 256'(1));
    chk("align_first_dst", 256'(last_out.dst), 256'(64'h10F8));
    chk("align_second_held", 256'(merge_active), 256'(1'b1));
    do_flush();
    idle(3);
    chk("align_second_dst", 256'(last_out.dst), 256'(64'h1100));

    // mixed size: two size=2 len=1 writes merge to len=3
    send(mkcmd(5'h05, 3'd2, 8'd1, 1'b0), 64'h7000, 64'hC0C0_C0C0_0000_0001);
    send(mkcmd(5'h05, 3'd2, 8'd1, 1'b0), 64'h7008, 64'hC1C1_C1C1_0000_0002);
    do_flush();
    idle(3);
    chk("size2_len", 256'(last_out.cmd[15:8]), 256'(3));
    chk("size2_data", last_out.data, 256'({64'hC1C1_C1C1_0000_0002, 64'hC0C0_C0C0_0000_0001}));

    // full aligned line without eom leaves on its own
    for (int i = 0; i < 4; i++) send(pw, 64'h8000 + 64'(i * 8), 64'(i + 100));
    idle(3);
    chk("full_dst", 256'(last_out.dst), 256'(64'h8000));
    chk("full_len", 256'(last_out.cmd[15:8]), 256'(3));
    chk("full_idle", 256'(merge_active), 256'(1'b0));

    // pass-through of non-posted requests
    rd = mkcmd(5'h01, 3'd3, 8'd0, 1'b1);
    wr = mkcmd(5'h03, 3'd3, 8'd0, 1'b1);
    send(rd, 64'h3000, 64'hDEAD_BEEF_0000_0001);
    send(wr, 64'h3008, 64'hFEED_F00D_0000_0002);
    chk("pass_no_wait", 256'(last_wait), 256'(0));
    chk("pass_read_cmd", 256'(last_out.cmd), 256'(32'h1840_0061));
    chk("pass_read_data", last_out.data, 256'(64'hDEAD_BEEF_0000_0001));
    chk("pass_write_valid", 256'(out_valid), 256'(1'b1));
    chk("pass_write_cmd", 256'(out_cmd), 256'(32'h1840_0063));
    idle(3);
    chk("pass_write_data", last_out.data, 256'(64'hFEED_F00D_0000_0002));

    // idle hold / timeout
    send(pw, 64'h6000, 64'hD0);
`ifdef UMI_MERGE_TIMEOUT_EN
    model_flush();
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid && first == 0) first = k;
    end
    chk("timeout_cycles", 256'(first), 256'(16));
`else
    first = 0;
    idle(20);
    chk("no_timeout_valid", 256'(out_valid), 256'(1'b0));
    chk("no_timeout_active", 256'(merge_active), 256'(1'b1));
    do_flush();
    idle(3);
`endif
    chk("hold_out_dst", 256'(last_out.dst), 256'(64'h6000));

    // backpressure
    out_ready = 1'b0;
    send(mkcmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h4000, 64'hE0);
    in_valid = 1'b1; in_cmd = rd; in_dst = 64'h4100; in_src = SRC; in_data = 64'hE1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", 256'(out_valid), 256'(1'b1));
      chk("bp_dst", 256'(out_dst), 256'(64'h4000));
      chk("bp_in_ready", 256'(in_ready), 256'(1'b0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("bp_sent_dst", 256'(last_out.dst), 256'(64'h4000));

    // reset while accumulating
    send(pw, 64'h5000, 64'hF0);
    idle(1);
    chk("pre_reset_active", 256'(merge_active), 256'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 256'(out_valid), 256'(1'b0));
    chk("reset_active", 256'(merge_active), 256'(1'b0));
    chk("reset_dst_cleared", 256'(out_dst), 256'(0));
    m_valid = 0;
    exp_q.delete();
    n0 = n_out;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    chk("reset_no_stale", 256'(n_out), 256'(n0));
    chk("reset_idle_valid", 256'(out_valid), 256'(1'b0));

    chk("drain_queue", 256'(exp_q.size()), 256'(0));
    chk("drain_held", 256'(m_valid), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
